reg_bank_seq: RTL and testbench
===============================

# reg_bank_seq

Write sequencer and arbiter for a bank of discrete-NFET register words built from `dff` cells. It shares the bank's single write path between up to NREQ requesters using round-robin priority. Each write is stretched into setup, strobe and hold phases, so data is stable around the flip-flop clock edge. It sits between the control unit's register-transfer requesters and the register bank's per-word clock and clear lines.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `NREG`, default 8: number of register words in the bank.
- `WIDTH`, default 12: register word width.
- `AW`, derived `$clog2(NREG)`: address width (localparam).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `clr`  in  1  reset; synchronous, active-high.
- `req`  in  NREQ  per-requester write request; level, held until own `gnt`.
- `req_addr`  in  NREQ*AW  packed target word addresses; requester i at `[i*AW +: AW]`.
- `req_data`  in  NREQ*WIDTH  packed write data; requester i at `[i*WIDTH +: WIDTH]`.
- `req_clear`  in  NREQ  per-requester clear command; ignored unless the clear feature is compiled in.
- `gnt`  out  NREQ  one-cycle completion pulse to the winning requester.
- `busy`  out  1  high whenever the state is not IDLE.
- `reg_data`  out  WIDTH  data driven onto the bank D inputs.
- `reg_sel`  out  NREG  one-hot target word select.
- `reg_clk`  out  NREG  one-hot word clock strobe.
- `reg_clr`  out  NREG  one-hot word clear strobe.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. The transition sequence is fixed: IDLE→SETUP→STROBE→HOLD→IDLE.
- IDLE:
  - If any `req` bit is set, the round-robin arbiter picks a winner w.
  - On that edge, w, `req_addr[w]`, `req_data[w]` and `req_clear[w]` are latched, and the state goes to SETUP.
  - Later changes on the requester inputs are ignored.
- SETUP: `reg_data` = latched data; `reg_sel` = one-hot of latched address; `reg_clk` and `reg_clr` are low.
- STROBE: same as SETUP, plus `reg_clk[addr]` high. When a latched clear is active, `reg_clr[addr]` is high instead of `reg_clk`.
- HOLD:
  - `reg_clk` and `reg_clr` are low.
  - `reg_data` and `reg_sel` keep their values.
  - `gnt[w]` is high for this cycle only.
- After HOLD: `reg_data` and `reg_sel` return to 0 in IDLE.
- Round-robin pointer:
  - The pointer is 0 after reset.
  - Search order is pointer, pointer+1, … mod NREQ.
  - After a grant to w, pointer = (w+1) mod NREQ.
- Out-of-range address (addr ≥ NREG): the full sequence runs with `reg_sel`, `reg_clk` and `reg_clr` all 0, and `gnt` still pulses.
- Requester drops `req` mid-operation: the operation completes and `gnt` still pulses.
- Requesters must deassert `req` in the cycle after `gnt`. A `req` still high in the following IDLE counts as a new request.

## Timing
- Reset value of every output is 0: `gnt`, `busy`, `reg_data`, `reg_sel`, `reg_clk`, `reg_clr`. The pointer resets to 0 and the state to IDLE.
- `clr` mid-operation aborts the operation at the next edge: no strobe, no `gnt`.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency for a request seen in IDLE at cycle 0:
  - SETUP at cycle 1.
  - Strobe at cycle 2.
  - `gnt` at cycle 3.
  - Next arbitration at cycle 4.
- Throughput is one write per 4 cycles.
- `busy` is high in cycles 1–3.

## Configuration
- `REG_BANK_SEQ_CLEAR_EN` defined:
  - `req_clear` is latched with the request.
  - A latched clear drives `reg_clr[addr]` in STROBE, and `reg_clk` stays low.
  - Clear takes precedence over data write.
- Macro undefined:
  - `req_clear` is ignored.
  - `reg_clr` is tied to 0.
  - All requests are data writes.

## Structure
- Shared package `q2_bank_pkg` holds:
  - the FSM state enum (`ST_IDLE`, `ST_SETUP`, `ST_STROBE`, `ST_HOLD`);
  - default widths (`Q2_WORD_W` = 12).
- One sub-module, `rr_arbiter`:
  - inputs: NREQ request vector and pointer;
  - outputs: one-hot grant and encoded index;
  - combinational only.
- Pointer and FSM live in `reg_bank_seq`.

## Test plan
- Reset then single write: `req[1]`, addr 3, data 0xA5C, no other requests.
  - `reg_clk[3]` high in cycle 2 only.
  - `reg_data` = 0xA5C in cycles 1–3.
  - `gnt[1]` in cycle 3.
- All four requesters held high, each dropping `req` the cycle after its own `gnt`: grants arrive in order 0,1,2,3, at cycles 3, 7, 11, 15.
- With macro defined: `req[2]` + `req_clear[2]`, addr 5. `reg_clr[5]` is high in cycle 2 and `reg_clk` stays 0. Without macro, the same stimulus strobes `reg_clk[5]`.
- `clr` asserted in STROBE cycle: next cycle all outputs are 0, state is IDLE, no `gnt`, and the pointer is 0.
- `NREG`=6, addr 7: no `reg_sel`/`reg_clk` activity and `gnt` pulses at cycle 3. Changing `req_data` during cycles 1–3 does not alter `reg_data`.

Source files
------------

// File: rtl/q2_bank_pkg.sv
// Shared definitions for the register-bank write sequencer.
//   q2_state_e : write sequencer FSM states
//   Q2_WORD_W  : default register word width
//   Q2_NREQ    : default number of requesters
//   Q2_NREG    : default number of register words
package q2_bank_pkg;

  localparam int Q2_WORD_W = 12;
  localparam int Q2_NREQ   = 4;
  localparam int Q2_NREG   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } q2_state_e;

endpackage

// File: rtl/reg_bank_seq_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Search starts at i_ptr and wraps modulo NREQ.
//   i_req [NREQ] : request vector
//   i_ptr [PW]   : highest-priority requester index
//   o_gnt [NREQ] : one-hot winner (0 if no request)
//   o_idx [PW]   : encoded winner index (0 if no request)
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx
);

  always_comb begin
    logic w_found;
    int   w_cand;
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      // Candidate at distance k from the pointer, wrapped without a modulo.
      w_cand = int'(i_ptr) + k;
      if (w_cand >= NREQ) w_cand = w_cand - NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!w_found && (j == w_cand) && i_req[j]) begin
          w_found  = 1'b1;
          o_gnt[j] = 1'b1;
          o_idx    = PW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/reg_bank_seq.sv
// reg_bank_seq: round-robin write sequencer for a dff register bank.
// Each write runs IDLE -> SETUP -> STROBE -> HOLD -> IDLE so the bank D
// inputs are stable a full cycle on either side of the word clock strobe.
// Optional feature macro: REG_BANK_SEQ_CLEAR_EN (clear-strobe commands).
//   clk, clr          : clock, synchronous active-high reset
//   req/req_addr/
//   req_data/req_clear: per-requester request, packed address/data, clear
//   gnt               : one-cycle completion pulse to the winner
//   busy              : sequencer not IDLE
//   reg_data/reg_sel/
//   reg_clk/reg_clr   : bank data, one-hot select, clock strobe, clear strobe
module reg_bank_seq
  import q2_bank_pkg::*;
#(
  parameter  int NREQ  = Q2_NREQ,
  parameter  int NREG  = Q2_NREG,
  parameter  int WIDTH = Q2_WORD_W,
  localparam int AW    = $clog2(NREG),
  localparam int PW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_clear,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      reg_data,
  output logic [NREG-1:0]       reg_sel,
  output logic [NREG-1:0]       reg_clk,
  output logic [NREG-1:0]       reg_clr
);

  q2_state_e        r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_win;
  logic [NREQ-1:0]  r_gnt;
  logic             r_busy;
  logic [WIDTH-1:0] r_reg_data;
  logic [NREG-1:0]  r_reg_sel;
  logic [NREG-1:0]  r_reg_clk;

  logic [NREQ-1:0]  w_gnt_oh;
  logic [PW-1:0]    w_idx;
  logic [AW-1:0]    w_win_addr;
  logic [WIDTH-1:0] w_win_data;
  logic [NREG-1:0]  w_win_sel;
  logic [PW-1:0]    w_ptr_nxt;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt_oh),
    .o_idx (w_idx)
  );

  assign w_win_addr = req_addr[int'(w_idx)*AW +: AW];
  assign w_win_data = req_data[int'(w_idx)*WIDTH +: WIDTH];
  assign w_ptr_nxt  = (r_win == PW'(NREQ-1)) ? '0 : r_win + 1'b1;

  // Addresses >= NREG decode to no select at all, so the sequence still
  // runs but touches no word.
  always_comb begin
    w_win_sel = '0;
    for (int j = 0; j < NREG; j++)
      if (int'(w_win_addr) == j) w_win_sel[j] = 1'b1;
  end

`ifdef REG_BANK_SEQ_CLEAR_EN
  logic            r_clear;
  logic [NREG-1:0] r_reg_clr;
  logic            w_unused_gnt;
  assign w_unused_gnt = |w_gnt_oh;
`else
  logic w_unused_in;
  assign w_unused_in = (^req_clear) ^ (|w_gnt_oh);
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_win      <= '0;
      r_gnt      <= '0;
      r_busy     <= 1'b0;
      r_reg_data <= '0;
      r_reg_sel  <= '0;
      r_reg_clk  <= '0;
`ifdef REG_BANK_SEQ_CLEAR_EN
      r_clear    <= 1'b0;
      r_reg_clr  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_state    <= ST_SETUP;
            r_busy     <= 1'b1;
            r_win      <= w_idx;
            r_reg_data <= w_win_data;
            r_reg_sel  <= w_win_sel;
`ifdef REG_BANK_SEQ_CLEAR_EN
            r_clear    <= req_clear[w_idx];
`endif
          end
        end
        ST_SETUP: begin
          r_state <= ST_STROBE;
`ifdef REG_BANK_SEQ_CLEAR_EN
          // Clear wins over a data write: strobe clr instead of clk.
          r_reg_clk <= r_clear ? '0 : r_reg_sel;
          r_reg_clr <= r_clear ? r_reg_sel : '0;
`else
          r_reg_clk <= r_reg_sel;
`endif
        end
        ST_STROBE: begin
          r_state   <= ST_HOLD;
          r_reg_clk <= '0;
`ifdef REG_BANK_SEQ_CLEAR_EN
          r_reg_clr <= '0;
`endif
          r_gnt     <= NREQ'(1) << r_win;
          r_ptr     <= w_ptr_nxt;
        end
        ST_HOLD: begin
          r_state    <= ST_IDLE;
          r_gnt      <= '0;
          r_busy     <= 1'b0;
          r_reg_data <= '0;
          r_reg_sel  <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign busy     = r_busy;
  assign reg_data = r_reg_data;
  assign reg_sel  = r_reg_sel;
  assign reg_clk  = r_reg_clk;
`ifdef REG_BANK_SEQ_CLEAR_EN
  assign reg_clr  = r_reg_clr;
`else
  assign reg_clr  = '0;
`endif

endmodule

// File: tb/tb_reg_bank_seq.sv
// Directed self-checking bench for reg_bank_seq (NREG=8 and NREG=6 builds).
module tb_reg_bank_seq;

  logic        clk, clr;
  logic [3:0]  req, req_clear;
  logic [11:0] req_addr;
  logic [47:0] req_data;
  logic [3:0]  gnt;
  logic        busy;
  logic [11:0] reg_data;
  logic [7:0]  reg_sel, reg_clk, reg_clr;

  logic [3:0]  req6, clear6;
  logic [11:0] addr6;
  logic [47:0] data6;
  logic [3:0]  gnt6;
  logic        busy6;
  logic [11:0] rdata6;
  logic [5:0]  sel6, clk6, clr6;

  int n_cmp = 0;
  int n_err = 0;

  reg_bank_seq #(.NREQ(4), .NREG(8), .WIDTH(12)) dut (
    .clk(clk), .clr(clr), .req(req), .req_addr(req_addr), .req_data(req_data),
    .req_clear(req_clear), .gnt(gnt), .busy(busy), .reg_data(reg_data),
    .reg_sel(reg_sel), .reg_clk(reg_clk), .reg_clr(reg_clr));

  reg_bank_seq #(.NREQ(4), .NREG(6), .WIDTH(12)) dut6 (
    .clk(clk), .clr(clr), .req(req6), .req_addr(addr6), .req_data(data6),
    .req_clear(clear6), .gnt(gnt6), .busy(busy6), .reg_data(rdata6),
    .reg_sel(sel6), .reg_clk(clk6), .reg_clr(clr6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    clr = 1'b1;
    step();
    step();
    clr = 1'b0;
  endtask

  logic [7:0] exp_clk, exp_clr;
  logic [3:0] exp_g;

  initial begin
    clr = 1'b0; req = '0; req_clear = '0; req_addr = '0; req_data = '0;
    req6 = '0; clear6 = '0; addr6 = '0; data6 = '0;

    // Reset state
    do_reset();
    chk("rst_gnt",  32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", 32'(reg_data), 0);
    chk("rst_sel",  32'(reg_sel), 0);
    chk("rst_clk",  32'(reg_clk), 0);
    chk("rst_clr",  32'(reg_clr), 0);
    chk("rst6_out", 32'({gnt6, busy6, rdata6, sel6, clk6, clr6}), 0);

    // Single write: requester 1, addr 3, data 0xA5C
    req = 4'b0010; req_addr[5:3] = 3'd3; req_data[23:12] = 12'hA5C;
    step(); // cycle 1
    chk("w1_c1_busy", 32'(busy), 1);
    chk("w1_c1_data", 32'(reg_data), 32'hA5C);
    chk("w1_c1_sel",  32'(reg_sel), 32'h08);
    chk("w1_c1_clk",  32'(reg_clk), 0);
    chk("w1_c1_gnt",  32'(gnt), 0);
    step(); // cycle 2
    chk("w1_c2_clk",  32'(reg_clk), 32'h08);
    chk("w1_c2_clr",  32'(reg_clr), 0);
    chk("w1_c2_data", 32'(reg_data), 32'hA5C);
    step(); // cycle 3
    chk("w1_c3_gnt",  32'(gnt), 32'h2);
    chk("w1_c3_clk",  32'(reg_clk), 0);
    chk("w1_c3_data", 32'(reg_data), 32'hA5C);
    chk("w1_c3_sel",  32'(reg_sel), 32'h08);
    step(); // cycle 4
    req = '0;
    chk("w1_c4_busy", 32'(busy), 0);
    chk("w1_c4_gnt",  32'(gnt), 0);
    chk("w1_c4_data", 32'(reg_data), 0);
    chk("w1_c4_sel",  32'(reg_sel), 0);

    // All four requesting from a fresh pointer: order 0,1,2,3
    do_reset();
    req_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    req_data = {12'h444, 12'h333, 12'h222, 12'h111};
    req = 4'b1111;
    for (int c = 1; c <= 16; c++) begin
      step();
      exp_g = 4'b0;
      if (c >= 3 && ((c - 3) % 4) == 0) exp_g = 4'(1) << ((c - 3) / 4);
      chk($sformatf("rr_gnt_c%0d", c), 32'(gnt), 32'(exp_g));
      if ((c % 4) == 1) begin
        chk($sformatf("rr_data_c%0d", c), 32'(reg_data), 32'(12'h111 * ((c - 1) / 4 + 1)));
        chk($sformatf("rr_sel_c%0d", c), 32'(reg_sel), 32'(8'(1) << ((c - 1) / 4)));
      end
      if (c >= 4 && (c % 4) == 0) req = req & ~(4'(1) << ((c - 4) / 4));
    end
    chk("rr_idle_busy", 32'(busy), 0);

    // Clear command: requester 2, addr 5
    req_addr[8:6] = 3'd5; req_data[35:24] = 12'h0C3;
    req_clear = 4'b0100; req = 4'b0100;
`ifdef REG_BANK_SEQ_CLEAR_EN
    exp_clk = 8'h00; exp_clr = 8'h20;
`else
    exp_clk = 8'h20; exp_clr = 8'h00;
`endif
    step(); // cycle 1
    chk("clr_c1_sel", 32'(reg_sel), 32'h20);
    chk("clr_c1_strb", 32'({reg_clk, reg_clr}), 0);
    step(); // cycle 2
    chk("clr_c2_clk", 32'(reg_clk), 32'(exp_clk));
    chk("clr_c2_clr", 32'(reg_clr), 32'(exp_clr));
    step(); // cycle 3
    chk("clr_c3_gnt", 32'(gnt), 32'h4);
    chk("clr_c3_strb", 32'({reg_clk, reg_clr}), 0);
    step(); // cycle 4
    req = '0; req_clear = '0;

    // Reset during STROBE aborts the write and zeroes the pointer
    req_addr[2:0] = 3'd1; req_data[11:0] = 12'h0F0; req = 4'b0001;
    step(); // cycle 1
    step(); // cycle 2
    chk("abort_c2_clk", 32'(reg_clk), 32'h02);
    clr = 1'b1;
    step(); // cycle 3
    chk("abort_gnt",  32'(gnt), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_data", 32'(reg_data), 0);
    chk("abort_strb", 32'({reg_sel, reg_clk, reg_clr}), 0);
    clr = 1'b0;
    // Pointer was 3 before the abort; a zeroed pointer picks requester 0
    req_addr[11:9] = 3'd6; req_data[47:36] = 12'h666; req = 4'b1001;
    step(); // cycle 4
    chk("abort_ptr_data", 32'(reg_data), 32'h0F0);
    chk("abort_ptr_sel",  32'(reg_sel), 32'h02);
    step();
    step(); // cycle 6
    chk("abort_ptr_gnt", 32'(gnt), 32'h1);
    step();
    req = '0;
    step();
    step();

    // NREG=6, out-of-range addr 7; requester drops req and data changes mid-op
    addr6[2:0] = 3'd7; data6[11:0] = 12'h123; req6 = 4'b0001;
    step(); // cycle 1
    req6 = '0; data6[11:0] = 12'hFFF;
    chk("oor_c1_busy", 32'(busy6), 1);
    chk("oor_c1_data", 32'(rdata6), 32'h123);
    chk("oor_c1_sel",  32'(sel6), 0);
    step(); // cycle 2
    chk("oor_c2_data", 32'(rdata6), 32'h123);
    chk("oor_c2_strb", 32'({sel6, clk6, clr6}), 0);
    step(); // cycle 3
    chk("oor_c3_gnt",  32'(gnt6), 32'h1);
    chk("oor_c3_data", 32'(rdata6), 32'h123);
    chk("oor_c3_strb", 32'({sel6, clk6, clr6}), 0);
    step(); // cycle 4
    chk("oor_c4_idle", 32'({gnt6, busy6, rdata6}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
